branch_exec_unit: RTL

//  Clocked, parametrised branch execution unit for the Cortex-M0 core. It accepts one branch
//  (B, B<cond>, BL, BX/BLX) per valid/ready handshake, evaluates the condition against NZCV,

---
 rtl/branch_exec_unit.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/branch_exec_unit.sv
// Branch execution unit: resolves B, B<cond>, BL and BX/BLX,
// then drives PC/LR write strobes and a fetch/decode flush window.
module branch_exec_unit #(
    parameter int DATA_W       = 32,
    parameter int PC_AHEAD     = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [1:0]        br_mode,
    input  logic              br_link,
    input  logic [3:0]        br_cond,
    input  logic [3:0]        flags_nzcv,
    input  logic [DATA_W-1:0] offset,
    input  logic [DATA_W-1:0] rm_val,
    input  logic [DATA_W-1:0] in_pc,
    output logic [DATA_W-1:0] pc_out,
    output logic              pc_we,
    output logic [DATA_W-1:0] lr_out,
    output logic              lr_we,
    output logic              flush,
    output logic              taken,
    output logic              fault,
    output logic              done
);

    localparam int CW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_FLUSH
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;

    logic [1:0]        r_mode;
    logic              r_link;
    logic [3:0]        r_cond;
    logic [3:0]        r_nzcv;
    logic [DATA_W-1:0] r_off;
    logic [DATA_W-1:0] r_rm;
    logic [DATA_W-1:0] r_pc;

    logic [DATA_W-1:0] r_pc_out;
    logic [DATA_W-1:0] r_lr_out;
    logic              r_pc_we;
    logic              r_lr_we;
    logic              r_flush;
    logic              r_taken;
    logic              r_fault;
    logic              r_done;

    logic              w_n;
    logic              w_z;
    logic              w_c;
    logic              w_v;
    logic              w_cond_ok;
    logic [DATA_W-1:0] w_rel;
    logic [DATA_W-1:0] w_target;
    logic [DATA_W-1:0] w_lr;
    logic              w_fault;
    logic              w_taken;
    logic              w_link;

    assign w_n = r_nzcv[3];
    assign w_z = r_nzcv[2];
    assign w_c = r_nzcv[1];
    assign w_v = r_nzcv[0];

    // Evaluate the latched condition code against the latched flags
    always_comb begin
        w_cond_ok = 1'b0;
        case (r_cond)
            4'h0:    w_cond_ok = w_z;
            4'h1:    w_cond_ok = !w_z;
            4'h2:    w_cond_ok = w_c;
            4'h3:    w_cond_ok = !w_c;
            4'h4:    w_cond_ok = w_n;
            4'h5:    w_cond_ok = !w_n;
            4'h6:    w_cond_ok = w_v;
            4'h7:    w_cond_ok = !w_v;
            4'h8:    w_cond_ok = w_c && !w_z;
            4'h9:    w_cond_ok = !w_c || w_z;
            4'hA:    w_cond_ok = (w_n == w_v);
            4'hB:    w_cond_ok = (w_n != w_v);
            4'hC:    w_cond_ok = !w_z && (w_n == w_v);
            4'hD:    w_cond_ok = w_z || (w_n != w_v);
            4'hE:    w_cond_ok = 1'b1;
            default: w_cond_ok = 1'b0;
        endcase
    end

    assign w_rel = (r_pc + DATA_W'(PC_AHEAD) + r_off)
                 & ~DATA_W'(1);

    assign w_target = (r_mode == 2'b11) ? (r_rm & ~DATA_W'(1)) : w_rel;

    // BX/BLX with bit0 clear would switch to ARM state, which the core lacks
    assign w_fault = (r_mode == 2'b11) && !r_rm[0];

    assign w_taken = !w_fault && ((r_mode != 2'b01) || w_cond_ok);

    assign w_link = (r_mode == 2'b10) || ((r_mode == 2'b11) && r_link);

    // BL is a 32-bit encoding, BLX a 16-bit one; bit0 marks Thumb state
    assign w_lr = (r_pc + ((r_mode == 2'b10) ? DATA_W'(4) : DATA_W'(2)))
                | DATA_W'(1);

    // Control FSM with registered strobes and held target/link values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_mode   <= '0;
            r_link   <= 1'b0;
            r_cond   <= '0;
            r_nzcv   <= '0;
            r_off    <= '0;
            r_rm     <= '0;
            r_pc     <= '0;
            r_pc_out <= '0;
            r_lr_out <= '0;
            r_pc_we  <= 1'b0;
            r_lr_we  <= 1'b0;
            r_flush  <= 1'b0;
            r_taken  <= 1'b0;
            r_fault  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_pc_we <= 1'b0;
            r_lr_we <= 1'b0;
            r_fault <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_flush <= 1'b0;
                    r_taken <= 1'b0;
                    if (br_valid) begin
                        r_mode  <= br_mode;
                        r_link  <= br_link;
                        r_cond  <= br_cond;
                        r_nzcv  <= flags_nzcv;
                        r_off   <= offset;
                        r_rm    <= rm_val;
                        r_pc    <= in_pc;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_taken <= w_taken;
                    r_fault <= w_fault;
                    if (w_taken) begin
                        r_pc_out <= w_target;
                        r_pc_we  <= 1'b1;
                        if (w_link) begin
                            r_lr_out <= w_lr;
                            r_lr_we  <= 1'b1;
                        end
                        if (FLUSH_CYCLES == 0) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_flush <= 1'b1;
                            r_cnt   <= CW'(FLUSH_CYCLES);
                            r_done  <= (FLUSH_CYCLES == 1);
                            r_state <= S_FLUSH;
                        end
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (r_cnt <= CW'(1)) begin
                        r_flush <= 1'b0;
                        r_taken <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt  <= r_cnt - CW'(1);
                        r_done <= (r_cnt == CW'(2));
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign br_ready = (r_state == S_IDLE);
    assign pc_out   = r_pc_out;
    assign lr_out   = r_lr_out;
    assign pc_we    = r_pc_we;
    assign lr_we    = r_lr_we;
    assign flush    = r_flush;
    assign taken    = r_taken;
    assign fault    = r_fault;
    assign done     = r_done;

endmodule
